// File: rtl/memory_cycle.sv
// Memory stage: word-wide data memory access, M/W pipeline register, write-back mux, perf counters.
// Latency 1 cycle M->W; no backpressure (no stall/flush, bubbles arrive as zero controls).
module memory_cycle #(
  parameter int DMEM_WORDS = 1024,
  parameter int AW         = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RegWriteM,
  input  logic        MemWriteM,
  input  logic [1:0]  ResultSrcM,
  input  logic [4:0]  RD_M,
  input  logic [31:0] PCPlus4M,
  input  logic [31:0] WriteDataM,
  input  logic [31:0] ALU_ResultM,
  input  logic        BranchM,
  input  logic        PerfClr,
  output logic        RegWriteW,
  output logic [4:0]  RD_W,
  output logic [1:0]  ResultSrcW,
  output logic [31:0] ReadDataW,
  output logic [31:0] ResultW,
  output logic [31:0] RetireCnt,
  output logic [31:0] LoadCnt,
  output logic [31:0] StoreCnt,
  output logic [31:0] BranchCnt
);

  // Contents survive rst; only the power-on value is defined.
  logic [31:0] r_mem [DMEM_WORDS] = '{default: '0};

  logic [AW-1:0] w_idx;
  logic [31:0]   w_rdata;

  logic          r_regwrite_w;
  logic [4:0]    r_rd_w;
  logic [1:0]    r_resultsrc_w;
  logic [31:0]   r_readdata_w;
  logic [31:0]   r_pcplus4_w;
  logic [31:0]   r_alu_w;

  logic [31:0]   r_retire_cnt;
  logic [31:0]   r_load_cnt;
  logic [31:0]   r_store_cnt;
  logic [31:0]   r_branch_cnt;

  assign w_idx   = ALU_ResultM[AW+1:2];
  assign w_rdata = r_mem[w_idx];

  // Read is taken combinationally before the edge, so a same-address store gives read-before-write.
  always_ff @(posedge clk) begin
    if (MemWriteM) begin
      r_mem[w_idx] <= WriteDataM;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_regwrite_w  <= 1'b0;
      r_rd_w        <= '0;
      r_resultsrc_w <= '0;
      r_readdata_w  <= '0;
      r_pcplus4_w   <= '0;
      r_alu_w       <= '0;
    end else begin
      r_regwrite_w  <= RegWriteM;
      r_rd_w        <= RD_M;
      r_resultsrc_w <= ResultSrcM;
      r_readdata_w  <= w_rdata;
      r_pcplus4_w   <= PCPlus4M;
      r_alu_w       <= ALU_ResultM;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_retire_cnt <= '0;
      r_load_cnt   <= '0;
      r_store_cnt  <= '0;
      r_branch_cnt <= '0;
    end else if (PerfClr) begin
      r_retire_cnt <= '0;
      r_load_cnt   <= '0;
      r_store_cnt  <= '0;
      r_branch_cnt <= '0;
    end else begin
      if (RegWriteM || MemWriteM || BranchM) r_retire_cnt <= r_retire_cnt + 32'd1;
      if (RegWriteM && (ResultSrcM == 2'b01)) r_load_cnt <= r_load_cnt + 32'd1;
      if (MemWriteM) r_store_cnt <= r_store_cnt + 32'd1;
      if (BranchM) r_branch_cnt <= r_branch_cnt + 32'd1;
    end
  end

  always_comb begin
    ResultW = 32'h0;
    case (r_resultsrc_w)
      2'b00:   ResultW = r_alu_w;
      2'b01:   ResultW = r_readdata_w;
      2'b10:   ResultW = r_pcplus4_w;
      default: ResultW = 32'h0;
    endcase
  end

  assign RegWriteW  = r_regwrite_w;
  assign RD_W       = r_rd_w;
  assign ResultSrcW = r_resultsrc_w;
  assign ReadDataW  = r_readdata_w;
  assign RetireCnt  = r_retire_cnt;
  assign LoadCnt    = r_load_cnt;
  assign StoreCnt   = r_store_cnt;
  assign BranchCnt  = r_branch_cnt;

endmodule

// File: doc/memory_cycle.md
# memory_cycle

Memory (M) stage of the five-stage RV32I pipeline, directly downstream of the execute stage. It consumes the execute-stage pipeline register outputs, performs word-wide data memory loads and stores, and registers results into the M/W pipeline register. It also produces the final write-back mux output `ResultW`, which is fed back for forwarding, and maintains performance counters for retired instructions, loads, stores and branches.

## Interface
- `DMEM_WORDS`, default 1024. Data memory depth in 32-bit words; must be a power of two.
- `AW`, default 10. Word-index width; equals log2(`DMEM_WORDS`).

- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `RegWriteM`  in  1  instruction in M writes the register file.
- `MemWriteM`  in  1  instruction in M is a store.
- `ResultSrcM`  in  2  write-back select: 00 ALU, 01 load data, 10 PC+4, 11 reserved.
- `RD_M`  in  5  destination register.
- `PCPlus4M`  in  32  PC+4 of the instruction in M.
- `WriteDataM`  in  32  store data, already forwarded.
- `ALU_ResultM`  in  32  ALU result or effective address.
- `BranchM`  in  1  instruction in M is a conditional branch.
- `PerfClr`  in  1  synchronous clear of all performance counters.
- `RegWriteW`  out  1  registered `RegWriteM`.
- `RD_W`  out  5  registered `RD_M`.
- `ResultSrcW`  out  2  registered `ResultSrcM`.
- `ReadDataW`  out  32  registered load data.
- `ResultW`  out  32  write-back value (combinational from W registers).
- `RetireCnt`  out  32  retired-instruction count.
- `LoadCnt`  out  32  load count.
- `StoreCnt`  out  32  store count.
- `BranchCnt`  out  32  branch count.

## Operation
- Word index = `ALU_ResultM[AW+1:2]`.
  - Bits [1:0] are ignored; misaligned addresses access the containing word.
  - Upper address bits are ignored, so addresses wrap modulo `DMEM_WORDS`*4.
- Store: when `MemWriteM`=1, the array word at the index is written with `WriteDataM` on the rising edge. Word stores only; there are no byte enables.
- Load: the array is read combinationally at the index every cycle and captured into `ReadDataW` on the edge, whether or not the instruction is a load.
- Read/write collision: when a store and the read address coincide in the same cycle, `ReadDataW` captures the old word (read-before-write). A load to that address in the following cycle returns the new data.
- Array contents are initialised to zero at time zero and are NOT cleared by `rst`.
- M/W register captures `RegWriteM`, `RD_M`, `ResultSrcM`, `PCPlus4M`, `ALU_ResultM` and the read data every cycle. There is no stall or flush input; a bubble arrives as all-zero controls.
- `ResultW` select on `ResultSrcW`:
  - 00: registered ALU result.
  - 01: `ReadDataW`.
  - 10: registered PC+4.
  - 11: 32'h0.
- Performance counters are 32-bit, wrap at 2^32, and increment on the edge, sampling the M-stage inputs:
  - `RetireCnt` += 1 if `RegWriteM` | `MemWriteM` | `BranchM`.
  - `LoadCnt` += 1 if `RegWriteM` & (`ResultSrcM`==01).
  - `StoreCnt` += 1 if `MemWriteM`.
  - `BranchCnt` += 1 if `BranchM`.
- `PerfClr`=1 zeroes all four counters on the edge and takes priority over a simultaneous increment.

## Timing
- Latency: M inputs appear on W outputs 1 cycle later. `ResultW` is valid in the same cycle as the W registers.
- A store is visible to a load issued in the next cycle; there is no memory hazard stall.
- Reset (asynchronous assert, any cycle including mid-store):
  - `RegWriteW`=0, `RD_W`=0, `ResultSrcW`=00, `ReadDataW`=0, `ResultW`=0.
  - The PC+4 and ALU W registers are 0.
  - All counters are 0.
- A store whose edge coincides with reset assertion is not required to complete. After release, the first edge captures normally.

## Test plan
- Reset: drive `rst`=0 mid-run -> all W outputs and counters read 0 immediately. Memory still returns previously stored data after release.
- Store then load: store 32'hDEADBEEF to address 0x40, then the next cycle load from 0x43 with `ResultSrcM`=01 -> one cycle later `ResultW`=32'hDEADBEEF and `RD_W` matches.
- Collision and wrap:
  - Store 32'h1 to 0x10 while the read address is 0x10 -> `ReadDataW` holds the old value; the following load gives 32'h1.
  - A store to 0x1010 aliases 0x10 when `DMEM_WORDS`=1024.
- Write-back mux:
  - `ResultSrcM`=10 with `PCPlus4M`=0x104 -> `ResultW`=0x104.
  - 00 -> ALU value.
  - 11 -> 0.
- Counters: issue 3 loads, 2 stores, 4 branches and 1 bubble -> `RetireCnt`=9, `LoadCnt`=3, `StoreCnt`=2, `BranchCnt`=4. Asserting `PerfClr` together with a branch -> `BranchCnt`=0.
- Counter wrap: force `RetireCnt` to 32'hFFFFFFFF, then retire one instruction -> `RetireCnt`=0.
